// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to data memory over a req/ack handshake,
// stalls the upstream pipe until completion, and flags misalignment and timeouts.
module mem_access_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      valid_in,
   input  logic                      mem_read_in,
   input  logic                      mem_write_in,
   input  logic [DATA_WIDTH-1:0]     alu_result_in,
   input  logic [DATA_WIDTH-1:0]     store_data_in,
   input  logic [REG_ADDR_WIDTH-1:0] reg_dest_in,
   output logic                      stall_out,
   output logic                      valid_out,
   output logic [DATA_WIDTH-1:0]     mem_data_out,
   output logic [DATA_WIDTH-1:0]     alu_result_out,
   output logic [REG_ADDR_WIDTH-1:0] reg_dest_out,
   output logic                      align_err_out,
   output logic                      bus_err_out,
   output logic                      dmem_req,
   output logic                      dmem_we,
   output logic [DATA_WIDTH-1:0]     dmem_addr,
   output logic [DATA_WIDTH-1:0]     dmem_wdata,
   input  logic [DATA_WIDTH-1:0]     dmem_rdata,
   input  logic                      dmem_ack,
   output logic                      fsm_state
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   // Handshake: dmem_req stays high and dmem_we/addr/wdata stay constant from the
   // issue edge until the edge closing the cycle in which dmem_ack is seen (or the
   // timeout cycle); the pipe sees valid_out exactly once, in that closing cycle.
   state_t                      state;
   logic [TW-1:0]               timer;
   logic                        lat_load;
   logic [DATA_WIDTH-1:0]       lat_alu;
   logic [REG_ADDR_WIDTH-1:0]   lat_dest;

   logic mem_op, misaligned, issue, timed_out, done;
   logic stall_c, valid_c, align_c, bus_c;

   assign mem_op     = valid_in & (mem_read_in | mem_write_in);
   assign misaligned = alu_result_in[1:0] != 2'b00;
   assign issue      = (state == IDLE) & mem_op & ~misaligned;
   assign timed_out  = timer == TW'(TIMEOUT_CYCLES - 1);
   assign done       = (state == BUSY) & (dmem_ack | timed_out);
   assign fsm_state  = (state == BUSY);

   always_comb begin
      stall_c        = 1'b0;
      valid_c        = 1'b0;
      align_c        = 1'b0;
      bus_c          = 1'b0;
      mem_data_out   = '0;
      alu_result_out = alu_result_in;
      reg_dest_out   = reg_dest_in;
      if (state == IDLE) begin
         if (issue) begin
            stall_c = 1'b1;
         end else begin
            valid_c = valid_in;
            align_c = mem_op & misaligned;
         end
      end else begin
         alu_result_out = lat_alu;
         reg_dest_out   = lat_dest;
         if (done) begin
            valid_c = 1'b1;
            bus_c   = ~dmem_ack;
            if (lat_load && dmem_ack) mem_data_out = dmem_rdata;
         end else begin
            stall_c = 1'b1;
         end
      end
   end

   // Control flags must be quiet while reset is asserted, independent of state.
   assign stall_out     = stall_c & reset_n;
   assign valid_out     = valid_c & reset_n;
   assign align_err_out = align_c & reset_n;
   assign bus_err_out   = bus_c & reset_n;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         timer      <= '0;
         lat_load   <= 1'b0;
         lat_alu    <= '0;
         lat_dest   <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  state      <= BUSY;
                  timer      <= '0;
                  lat_load   <= mem_read_in;
                  lat_alu    <= alu_result_in;
                  lat_dest   <= reg_dest_in;
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write_in;
                  dmem_addr  <= {alu_result_in[DATA_WIDTH-1:2], 2'b00};
                  dmem_wdata <= store_data_in;
               end
            end
            BUSY: begin
               if (done) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
